// File: rtl/w0rm_multicycle_pkg.sv
// rtl/w0rm_multicycle_pkg.sv - shared state encoding and helpers for start/stop initiators
package w0rm_multicycle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } mc_state_e;

    // Bits needed to hold values 0 .. value-1.
    function automatic int w0rm_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/w0rm_mc_watchdog.sv
// rtl/w0rm_mc_watchdog.sv - saturating cycle counter with clear/enable and expired flag
module w0rm_mc_watchdog #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT_W);

endmodule

// File: rtl/w0rm_multicycle_ctrl.sv
// rtl/w0rm_multicycle_ctrl.sv - start/stop timer initiator; watchdog under W0RM_MULTICYCLE_WATCHDOG_EN
module w0rm_multicycle_ctrl
    import w0rm_multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic [DATA_WIDTH-1:0] op_data,
    output logic                  timer_start,
    input  logic                  timer_stop,
    input  logic [DATA_WIDTH-1:0] result_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_timeout,
    output logic                  busy,
    output logic                  err_stray_stop
);

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("w0rm_multicycle_ctrl: TIMEOUT must be >= 1");
    end

    mc_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic                  err_stray_q, err_stray_d;
    logic                  wd_expired;

`ifdef W0RM_MULTICYCLE_WATCHDOG_EN
    localparam int WD_W = w0rm_clog2(TIMEOUT + 1);

    w0rm_mc_watchdog #(
        .WIDTH (WD_W),
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == ST_ARM),
        .en_i      ((state_q == ST_WAIT) && !timer_stop),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        op_data_d      = op_data_q;
        resp_data_d    = resp_data_q;
        resp_timeout_d = resp_timeout_q;
        // A stop is only meaningful while waiting; anywhere else it is a protocol error.
        err_stray_d    = err_stray_q | (timer_stop && (state_q != ST_WAIT));

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_data_d = req_data;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer_stop) begin
                    resp_data_d    = result_data;
                    resp_timeout_d = 1'b0;
                    state_d        = ST_RESP;
                end else if (wd_expired) begin
                    resp_data_d    = '0;
                    resp_timeout_d = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_data_q      <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
            err_stray_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_data_q      <= op_data_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
            err_stray_q    <= err_stray_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign timer_start    = (state_q == ST_ARM);
    assign resp_valid     = (state_q == ST_RESP);
    assign busy           = (state_q != ST_IDLE);
    assign op_data        = op_data_q;
    assign resp_data      = resp_data_q;
    assign resp_timeout   = resp_timeout_q;
    assign err_stray_stop = err_stray_q;

endmodule

// File: tb/tb_w0rm_multicycle_ctrl.sv
// tb/tb_w0rm_multicycle_ctrl.sv - directed self-checking bench for w0rm_multicycle_ctrl
`timescale 1ns/1ps
module tb_w0rm_multicycle_ctrl;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic [DW-1:0] op_data;
    logic          timer_start;
    logic          timer_stop;
    logic [DW-1:0] result_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_timeout;
    logic          busy;
    logic          err_stray_stop;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    w0rm_multicycle_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .op_data        (op_data),
        .timer_start    (timer_start),
        .timer_stop     (timer_stop),
        .result_data    (result_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_timeout   (resp_timeout),
        .busy           (busy),
        .err_stray_stop (err_stray_stop)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_data = '0; timer_stop = 1'b0;
        result_data = '0; resp_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        n_checks++;
        if ({req_ready, timer_start, resp_valid, resp_timeout, busy, err_stray_stop} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {req_ready, timer_start, resp_valid, resp_timeout, busy, err_stray_stop});
        else n_pass++;
        n_checks++;
        if (op_data !== 32'h0 || resp_data !== 32'h0)
            $display("FAIL reset_data: got op=%h resp=%h expected 0/0", op_data, resp_data);
        else n_pass++;
    endtask

    // Timer paired with LOAD=0, LIMIT=4: stop lands at T+6, response at T+7.
    task automatic test_normal;
        int start_cnt = 0;
        int start_cyc = -1;
        int resp_cyc  = -1;
        req_valid = 1'b1; req_data = 32'hA5A5_0001; result_data = 32'hDEAD_DEAD;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL normal_req_ready: got %b expected 1", req_ready);
        else n_pass++;
        for (int c = 1; c <= 7; c++) begin
            tick();
            req_valid = 1'b0; timer_stop = 1'b0; result_data = 32'hDEAD_DEAD;
            if (timer_start === 1'b1) begin start_cnt++; start_cyc = c; end
            if (resp_valid === 1'b1 && resp_cyc < 0) resp_cyc = c;
            if (c == 6) begin timer_stop = 1'b1; result_data = 32'h0000_1234; end
        end
        n_checks++;
        if (start_cnt !== 1 || start_cyc !== 1)
            $display("FAIL normal_start: got count=%0d cycle=%0d expected 1/1", start_cnt, start_cyc);
        else n_pass++;
        n_checks++;
        if (resp_cyc !== 7) $display("FAIL normal_resp_cycle: got %0d expected 7", resp_cyc);
        else n_pass++;
        n_checks++;
        if (resp_data !== 32'h1234 || resp_timeout !== 1'b0 || op_data !== 32'hA5A5_0001)
            $display("FAIL normal_resp: got data=%h to=%b op=%h expected 00001234/0/a5a50001",
                     resp_data, resp_timeout, op_data);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL normal_return: got valid=%b ready=%b expected 0/1", resp_valid, req_ready);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int resp_cyc = -1;
        int bad      = 0;
        req_valid = 1'b1; req_data = 32'h0000_0077;
`ifdef W0RM_MULTICYCLE_WATCHDOG_EN
        for (int c = 1; c <= 11; c++) begin
            tick();
            req_valid = 1'b0;
            if (resp_valid === 1'b1 && resp_cyc < 0) resp_cyc = c;
        end
        n_checks++;
        if (resp_cyc !== 11) $display("FAIL timeout_cycle: got %0d expected 11", resp_cyc);
        else n_pass++;
        n_checks++;
        if (resp_timeout !== 1'b1 || resp_data !== 32'h0)
            $display("FAIL timeout_resp: got to=%b data=%h expected 1/00000000", resp_timeout, resp_data);
        else n_pass++;
`else
        for (int c = 1; c <= 40; c++) begin
            tick();
            req_valid = 1'b0;
            if (busy !== 1'b1 || resp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL timeout_disabled_busy: got %0d bad cycles expected 0", bad);
        else n_pass++;
        timer_stop = 1'b1; result_data = 32'h0000_0055;
        tick();
        timer_stop = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b1 || resp_timeout !== 1'b0 || resp_data !== 32'h55)
            $display("FAIL timeout_disabled_resp: got v=%b to=%b data=%h expected 1/0/00000055",
                     resp_valid, resp_timeout, resp_data);
        else n_pass++;
`endif
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Stop lands in the cycle the watchdog reaches TIMEOUT (T+2+TO).
    task automatic test_stop_wins;
        int resp_cyc = -1;
        req_valid = 1'b1; req_data = 32'h0000_0099;
        for (int c = 1; c <= 11; c++) begin
            tick();
            req_valid = 1'b0; timer_stop = 1'b0; result_data = 32'h0;
            if (resp_valid === 1'b1 && resp_cyc < 0) resp_cyc = c;
            if (c == 10) begin timer_stop = 1'b1; result_data = 32'hCAFE_F00D; end
        end
        n_checks++;
        if (resp_cyc !== 11) $display("FAIL stop_wins_cycle: got %0d expected 11", resp_cyc);
        else n_pass++;
        n_checks++;
        if (resp_timeout !== 1'b0 || resp_data !== 32'hCAFE_F00D)
            $display("FAIL stop_wins_resp: got to=%b data=%h expected 0/cafef00d", resp_timeout, resp_data);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_back_pressure;
        int bad = 0;
        req_valid = 1'b1; req_data = 32'h0000_0011;
        for (int c = 1; c <= 3; c++) begin
            tick();
            req_valid = 1'b0; timer_stop = 1'b0; result_data = 32'h0;
            if (c == 2) begin timer_stop = 1'b1; result_data = 32'h0000_BEEF; end
        end
        n_checks++;
        if (resp_valid !== 1'b1) $display("FAIL bp_first_valid: got %b expected 1", resp_valid);
        else n_pass++;
        req_valid = 1'b1; req_data = 32'h0000_0022; resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_data !== 32'hBEEF || req_ready !== 1'b0 ||
                op_data !== 32'h11) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0; resp_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || op_data !== 32'h11)
            $display("FAIL bp_no_same_cycle_accept: got busy=%b ready=%b op=%h expected 0/1/00000011",
                     busy, req_ready, op_data);
        else n_pass++;
    endtask

    task automatic test_stray_stop;
        int bad = 0;
        timer_stop = 1'b1;
        tick();
        timer_stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (err_stray_stop !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL stray_sticky: got %0d bad cycles expected 0", bad);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (err_stray_stop !== 1'b0) $display("FAIL stray_clear: got %b expected 0", err_stray_stop);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_data = 32'h0000_0033;
        for (int c = 1; c <= 4; c++) begin
            tick();
            req_valid = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midreset_in_wait: got busy=%b expected 1", busy);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || err_stray_stop !== 1'b0)
            $display("FAIL midreset_idle: got busy=%b v=%b rdy=%b err=%b expected 0/0/1/0",
                     busy, resp_valid, req_ready, err_stray_stop);
        else n_pass++;
        timer_stop = 1'b1; result_data = 32'h0000_0044;
        tick();
        timer_stop = 1'b0;
        n_checks++;
        if (err_stray_stop !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_late_stop: got err=%b v=%b busy=%b expected 1/0/0",
                     err_stray_stop, resp_valid, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_stop_wins();
        test_back_pressure();
        test_stray_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
